// File: rtl/uart_cmd_pkg.sv
// Shared types and command constants for the UART command receiver.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam logic [7:0] CMD_BACK  = 8'h62;
    localparam logic [7:0] CMD_FWD   = 8'h66;
    localparam logic [7:0] CMD_RIGHT = 8'h72;
    localparam logic [7:0] CMD_LEFT  = 8'h6C;

    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b == CMD_BACK) || (b == CMD_FWD) || (b == CMD_RIGHT) || (b == CMD_LEFT);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; both flops reset to the idle level (1).
module uart_rx_sync (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver that decodes single-byte robot commands.
// Optional idle timeout that clears the held command: define UART_CMD_RX_TIMEOUT_EN.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int TIMEOUT_CYCLES = 25_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] rx_data,
    output logic       rx_cnt_en,
    output logic       cmd_known,
    output logic       frame_err,
    output logic       busy,
    output logic       timeout
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rxs;
    rx_state_t   state, state_n;
    logic [15:0] bit_cnt, bit_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift_reg, shift_n;
    logic        accept;
    logic        bad_stop;

    uart_rx_sync u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .din  (RXD),
        .dout (rxs)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            rx_cnt_en <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
            rx_cnt_en <= accept;
            frame_err <= bad_stop;
        end
    end

    // Every counting state stops at its compare value, so bit_cnt never wraps.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        accept    = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n   = START;
                    bit_cnt_n = 16'd0;
                end
            end
            START: begin
                if (bit_cnt == HALF_LAST) begin
                    bit_cnt_n = 16'd0;
                    bit_idx_n = 3'd0;
                    state_n   = rxs ? IDLE : DATA;
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n          = 16'd0;
                    shift_n[bit_idx]   = rxs;
                    bit_idx_n          = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = 16'd0;
                    if (rxs) begin
                        accept  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        bad_stop = 1'b1;
                        state_n  = WAIT_HIGH;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rxs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

`ifdef UART_CMD_RX_TIMEOUT_EN
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [31:0] to_cnt;
    logic        to_fire;

    // A byte accepted on the firing edge restarts the count instead of clearing.
    assign to_fire = !accept && (to_cnt == TO_LIMIT - 32'd1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt    <= 32'd0;
            timeout   <= 1'b0;
            rx_data   <= 8'h00;
            cmd_known <= 1'b0;
        end else begin
            timeout <= to_fire;
            if (accept) begin
                to_cnt    <= 32'd0;
                rx_data   <= shift_reg;
                cmd_known <= is_known_cmd(shift_reg);
            end else begin
                if (to_cnt != TO_LIMIT) begin
                    to_cnt <= to_cnt + 32'd1;
                end
                if (to_fire) begin
                    rx_data   <= 8'h00;
                    cmd_known <= 1'b0;
                end
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_data   <= 8'h00;
            cmd_known <= 1'b0;
        end else if (accept) begin
            rx_data   <= shift_reg;
            cmd_known <= is_known_cmd(shift_reg);
        end
    end
`endif

endmodule
